// File: rtl/rsa_mult_arb.sv
// rsa_mult_arb: round-robin arbiter sharing one modular multiplier between two requesters.
// Optional macro RSA_ARB_TIMEOUT_EN aborts a WAIT that exceeds TIMEOUT cycles.
module rsa_mult_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  arb_clk,
    input  logic                  arb_rst,
    input  logic                  r0_start,
    input  logic [DATA_WIDTH-1:0] r0_a,
    input  logic [DATA_WIDTH-1:0] r0_b,
    input  logic [DATA_WIDTH-1:0] r0_n,
    output logic                  r0_busy,
    output logic                  r0_done,
    output logic                  r0_err,
    output logic [DATA_WIDTH-1:0] r0_dout,
    input  logic                  r1_start,
    input  logic [DATA_WIDTH-1:0] r1_a,
    input  logic [DATA_WIDTH-1:0] r1_b,
    input  logic [DATA_WIDTH-1:0] r1_n,
    output logic                  r1_busy,
    output logic                  r1_done,
    output logic                  r1_err,
    output logic [DATA_WIDTH-1:0] r1_dout,
    output logic                  mul_start,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    output logic [DATA_WIDTH-1:0] mul_n,
    input  logic                  mul_done,
    input  logic [DATA_WIDTH-1:0] mul_dout,
    output logic                  arb_owner,
    output logic                  arb_active
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RETURN = 2'd3;

    logic [1:0]            state_reg, state_next;
    logic                  owner_reg, owner_next;
    logic                  last_grant_reg;
    logic [DATA_WIDTH-1:0] mul_a_reg, mul_b_reg, mul_n_reg;

    logic [1:0]            start_vec, pend_vec, done_vec, err_vec;
    logic [DATA_WIDTH-1:0] a_in   [2];
    logic [DATA_WIDTH-1:0] b_in   [2];
    logic [DATA_WIDTH-1:0] n_in   [2];
    logic [DATA_WIDTH-1:0] a_vec  [2];
    logic [DATA_WIDTH-1:0] b_vec  [2];
    logic [DATA_WIDTH-1:0] n_vec  [2];
    logic [DATA_WIDTH-1:0] dout_vec [2];

    logic                  grant;
    logic                  result_we;
    logic [DATA_WIDTH-1:0] result_val;
    logic                  timeout_hit;
    logic                  err_flag;

    assign start_vec = {r1_start, r0_start};
    assign a_in[0] = r0_a;
    assign b_in[0] = r0_b;
    assign n_in[0] = r0_n;
    assign a_in[1] = r1_a;
    assign b_in[1] = r1_b;
    assign n_in[1] = r1_n;

    // With both pending, the requester that did not win last time is granted.
    always_comb begin
        grant = pend_vec[1];
        if (pend_vec == 2'b11) begin
            grant = ~last_grant_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        result_we  = 1'b0;
        result_val = mul_dout;
        case (state_reg)
            ST_IDLE: begin
                if (|pend_vec) begin
                    state_next = ST_ISSUE;
                    owner_next = grant;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (mul_done) begin
                    result_we  = 1'b1;
                    state_next = ST_RETURN;
                end else if (timeout_hit) begin
                    result_we  = 1'b1;
                    result_val = '1;
                    state_next = ST_RETURN;
                end
            end
            ST_RETURN: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            mul_a_reg      <= '0;
            mul_b_reg      <= '0;
            mul_n_reg      <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            if (state_reg == ST_IDLE && |pend_vec) begin
                mul_a_reg <= a_vec[grant];
                mul_b_reg <= b_vec[grant];
                mul_n_reg <= n_vec[grant];
            end
            if (state_reg == ST_RETURN) begin
                last_grant_reg <= owner_reg;
            end
        end
    end

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    assign timeout_hit = (state_reg == ST_WAIT) && (cnt_reg == CNT_W'(TIMEOUT - 1));
    assign err_flag    = err_reg;

    // A completion in the last WAIT cycle takes priority over the abort.
    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_ISSUE) begin
                cnt_reg <= '0;
            end else if (state_reg == ST_WAIT && !mul_done) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == ST_WAIT) begin
                err_reg <= timeout_hit && !mul_done;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_flag    = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            localparam logic IDX = 1'(gi);

            logic                  pend_reg;
            logic [DATA_WIDTH-1:0] a_reg, b_reg, n_reg, dout_reg;
            logic                  ret_own, accept;

            assign ret_own = (state_reg == ST_RETURN) && (owner_reg == IDX);
            // A new request in this requester's own RETURN cycle re-arms pend.
            assign accept  = start_vec[gi] && (!pend_reg || ret_own);

            always_ff @(posedge arb_clk) begin
                if (arb_rst) begin
                    pend_reg <= 1'b0;
                    a_reg    <= '0;
                    b_reg    <= '0;
                    n_reg    <= '0;
                    dout_reg <= '0;
                end else begin
                    if (accept) begin
                        pend_reg <= 1'b1;
                        a_reg    <= a_in[gi];
                        b_reg    <= b_in[gi];
                        n_reg    <= n_in[gi];
                    end else if (ret_own) begin
                        pend_reg <= 1'b0;
                    end
                    if (result_we && owner_reg == IDX) begin
                        dout_reg <= result_val;
                    end
                end
            end

            assign pend_vec[gi] = pend_reg;
            assign done_vec[gi] = ret_own;
            assign err_vec[gi]  = ret_own && err_flag;
            assign a_vec[gi]    = a_reg;
            assign b_vec[gi]    = b_reg;
            assign n_vec[gi]    = n_reg;
            assign dout_vec[gi] = dout_reg;
        end
    endgenerate

    assign r0_busy    = pend_vec[0];
    assign r0_done    = done_vec[0];
    assign r0_err     = err_vec[0];
    assign r0_dout    = dout_vec[0];
    assign r1_busy    = pend_vec[1];
    assign r1_done    = done_vec[1];
    assign r1_err     = err_vec[1];
    assign r1_dout    = dout_vec[1];
    assign mul_start  = (state_reg == ST_ISSUE);
    assign mul_a      = mul_a_reg;
    assign mul_b      = mul_b_reg;
    assign mul_n      = mul_n_reg;
    assign arb_owner  = owner_reg;
    assign arb_active = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_rsa_mult_arb.sv
// Bench for rsa_mult_arb: transaction scoreboard with a rule-level arbitration model.
// The timeout scenario is compiled in only when RSA_ARB_TIMEOUT_EN is defined.
module tb_rsa_mult_arb;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          arb_clk = 1'b0;
    logic          arb_rst;
    logic          r0_start, r1_start;
    logic [DW-1:0] r0_a, r0_b, r0_n, r1_a, r1_b, r1_n;
    logic          r0_busy, r0_done, r0_err, r1_busy, r1_done, r1_err;
    logic [DW-1:0] r0_dout, r1_dout;
    logic          mul_start;
    logic [DW-1:0] mul_a, mul_b, mul_n;
    logic          mul_done;
    logic [DW-1:0] mul_dout;
    logic          arb_owner, arb_active;

    always #5 arb_clk = ~arb_clk;

    rsa_mult_arb #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .arb_clk(arb_clk), .arb_rst(arb_rst),
        .r0_start(r0_start), .r0_a(r0_a), .r0_b(r0_b), .r0_n(r0_n),
        .r0_busy(r0_busy), .r0_done(r0_done), .r0_err(r0_err), .r0_dout(r0_dout),
        .r1_start(r1_start), .r1_a(r1_a), .r1_b(r1_b), .r1_n(r1_n),
        .r1_busy(r1_busy), .r1_done(r1_done), .r1_err(r1_err), .r1_dout(r1_dout),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
        .mul_done(mul_done), .mul_dout(mul_dout),
        .arb_owner(arb_owner), .arb_active(arb_active)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: pending requests as {a,b,n}, plus service bookkeeping.
    logic [23:0] q0[$];
    logic [23:0] q1[$];
    int   cyc = 0;
    logic prev_idle, prev_p0, prev_p1;
    logic in_service, svc_owner, last_served;
    logic exp_done0, exp_done1, exp_tmo;
    logic mul_active, hang, stray;
    int   mul_due, start_cyc, last_start_cyc, last_done_cyc, lat_force;
    int   done_cnt0 = 0;
    int   order_q[$];

    function automatic logic [7:0] modmul(input logic [23:0] op);
        int a, b, n;
        a = int'(op[23:16]);
        b = int'(op[15:8]);
        n = int'(op[7:0]);
        if (n == 0) return 8'h00;
        return 8'((a * b) % n);
    endfunction

    function automatic logic [23:0] rand_op();
        return {8'($urandom), 8'($urandom), 8'($urandom_range(1, 255))};
    endfunction

    function automatic int order_code();
        int code = 0;
        foreach (order_q[i]) code = code * 10 + order_q[i] + 1;
        return code;
    endfunction

    task automatic retire(input int k);
        logic [23:0] op;
        logic [7:0]  exp_val;
        logic [7:0]  got;
        logic        got_err;
        got     = (k == 1) ? r1_dout : r0_dout;
        got_err = (k == 1) ? r1_err : r0_err;
        if ((k == 1 ? q1.size() : q0.size()) == 0) begin
            check_eq("done_without_request", 64'(k), 64'hFF);
            return;
        end
        op      = (k == 1) ? q1.pop_front() : q0.pop_front();
        exp_val = exp_tmo ? 8'hFF : modmul(op);
        check_eq(k == 1 ? "r1_dout" : "r0_dout", 64'(got), 64'(exp_val));
        check_eq(k == 1 ? "r1_err" : "r0_err", 64'(got_err), 64'(exp_tmo));
        $display("txn r%0d a=%0d b=%0d n=%0d dout=%0d err=%0d cycle=%0d",
                 k, op[23:16], op[15:8], op[7:0], got, got_err, cyc);
        last_served   = (k == 1);
        last_done_cyc = cyc;
        order_q.push_back(k);
        if (k == 0) done_cnt0++;
    endtask

    task automatic observe();
        logic        p0, p1, exp_start, exp_owner;
        logic [23:0] op;
        p0 = (q0.size() != 0);
        p1 = (q1.size() != 0);
        exp_start = prev_idle && (prev_p0 || prev_p1);
        check_eq("mul_start", 64'(mul_start), 64'(exp_start));
        check_eq("r0_busy", 64'(r0_busy), 64'(p0));
        check_eq("r1_busy", 64'(r1_busy), 64'(p1));
        if (exp_start) begin
            exp_owner = (prev_p0 && prev_p1) ? ~last_served : prev_p1;
            check_eq("arb_owner", 64'(arb_owner), 64'(exp_owner));
            op = 24'h0;
            if (exp_owner && q1.size() != 0) op = q1[0];
            if (!exp_owner && q0.size() != 0) op = q0[0];
            check_eq("mul_operands", 64'({mul_a, mul_b, mul_n}), 64'(op));
            in_service     = 1'b1;
            svc_owner      = exp_owner;
            mul_active     = 1'b1;
            start_cyc      = cyc;
            last_start_cyc = cyc;
            mul_due = hang ? -1 : cyc + ((lat_force > 0) ? lat_force : int'($urandom_range(1, 4)));
        end
        check_eq("arb_active", 64'(arb_active), 64'(in_service));
        check_eq("r0_done", 64'(r0_done), 64'(exp_done0));
        check_eq("r1_done", 64'(r1_done), 64'(exp_done1));
        if (exp_done0) retire(0);
        if (exp_done1) retire(1);
        prev_idle = !in_service;
        prev_p0   = p0;
        prev_p1   = p1;
        if (exp_done0 || exp_done1) in_service = 1'b0;
        exp_done0 = 1'b0;
        exp_done1 = 1'b0;
        exp_tmo   = 1'b0;
    endtask

    task automatic drive(input logic s0, input logic [23:0] op0, input logic s1, input logic [23:0] op1);
        r0_start = s0;
        {r0_a, r0_b, r0_n} = op0;
        r1_start = s1;
        {r1_a, r1_b, r1_n} = op1;
        if (s0 && q0.size() == 0) q0.push_back(op0);
        if (s1 && q1.size() == 0) q1.push_back(op1);
        mul_done = 1'b0;
        mul_dout = 8'($urandom);
        if (mul_active && cyc == mul_due) begin
            mul_done   = 1'b1;
            mul_dout   = modmul({mul_a, mul_b, mul_n});
            mul_active = 1'b0;
            if (svc_owner) exp_done1 = 1'b1;
            else           exp_done0 = 1'b1;
        end
`ifdef RSA_ARB_TIMEOUT_EN
        else if (mul_active && mul_due < 0 && cyc == start_cyc + TO) begin
            mul_active = 1'b0;
            exp_tmo    = 1'b1;
            if (svc_owner) exp_done1 = 1'b1;
            else           exp_done0 = 1'b1;
        end
`endif
        if (stray) begin
            mul_done = 1'b1;
            mul_dout = 8'h5A;
        end
        @(posedge arb_clk);
        #1;
        cyc++;
    endtask

    task automatic tick(input logic s0, input logic [23:0] op0, input logic s1, input logic [23:0] op1);
        observe();
        drive(s0, op0, s1, op1);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 24'h0, 1'b0, 24'h0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && !in_service) break;
            tick(1'b0, 24'h0, 1'b0, 24'h0);
        end
        check_eq("drain_complete", 64'(q0.size() + q1.size()), 64'h0);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({r0_busy, r0_done, r0_err, r0_dout, r1_busy, r1_done, r1_err, r1_dout,
                    mul_start, mul_a, mul_b, mul_n, arb_owner, arb_active});
    endfunction

    task automatic do_reset();
        arb_rst  = 1'b1;
        r0_start = 1'b0;
        r1_start = 1'b0;
        mul_done = 1'b0;
        mul_dout = '0;
        stray    = 1'b0;
        hang     = 1'b0;
        repeat (2) @(posedge arb_clk);
        #1;
        arb_rst = 1'b0;
        q0.delete();
        q1.delete();
        order_q.delete();
        prev_idle   = 1'b1;
        prev_p0     = 1'b0;
        prev_p1     = 1'b0;
        in_service  = 1'b0;
        svc_owner   = 1'b0;
        last_served = 1'b1;
        exp_done0   = 1'b0;
        exp_done1   = 1'b0;
        exp_tmo     = 1'b0;
        mul_active  = 1'b0;
        mul_due     = -1;
        lat_force   = 0;
        check_eq("reset_outputs", all_outputs(), 64'h0);
    endtask

    initial begin
        int t0, cnt_before;
        logic [23:0] op_a, op_b;

        // Single request, one-cycle multiplier.
        do_reset();
        lat_force = 1;
        t0 = cyc;
        tick(1'b1, {8'd3, 8'd5, 8'd7}, 1'b0, 24'h0);
        drain(20);
        check_eq("first_mul_start_cycle", 64'(last_start_cyc - t0), 64'd2);
        check_eq("first_done_cycle", 64'(last_done_cyc - t0), 64'd4);
        check_eq("first_dout", 64'(r0_dout), 64'd1);

        // Simultaneous pair, then a lone r0, then another pair: grants alternate.
        do_reset();
        tick(1'b1, rand_op(), 1'b1, rand_op());
        drain(40);
        check_eq("pair1_order", 64'(order_code()), 64'd12);
        order_q.delete();
        tick(1'b1, rand_op(), 1'b0, 24'h0);
        drain(40);
        order_q.delete();
        tick(1'b1, rand_op(), 1'b1, rand_op());
        drain(40);
        check_eq("pair2_order", 64'(order_code()), 64'd21);

        // r1 waits behind r0; r0 re-requests in its own RETURN cycle.
        do_reset();
        tick(1'b1, rand_op(), 1'b0, 24'h0);
        tick(1'b0, 24'h0, 1'b1, rand_op());
        begin
            logic restarted = 1'b0;
            for (int i = 0; i < 60 && order_q.size() < 3; i++) begin
                observe();
                if (r0_done && !restarted) begin
                    restarted = 1'b1;
                    drive(1'b1, rand_op(), 1'b0, 24'h0);
                end else begin
                    drive(1'b0, 24'h0, 1'b0, 24'h0);
                end
            end
        end
        drain(40);
        check_eq("return_restart_order", 64'(order_code()), 64'd121);

        // Start while busy is ignored; original operands are used.
        do_reset();
        lat_force  = 3;
        cnt_before = done_cnt0;
        op_a = {8'd11, 8'd13, 8'd17};
        op_b = {8'd200, 8'd100, 8'd9};
        tick(1'b1, op_a, 1'b0, 24'h0);
        tick(1'b1, op_b, 1'b0, 24'h0);
        drain(30);
        check_eq("busy_ignore_count", 64'(done_cnt0 - cnt_before), 64'd1);
        check_eq("busy_ignore_dout", 64'(r0_dout), 64'(modmul(op_a)));

        // Reset in WAIT, then a stray completion.
        do_reset();
        hang = 1'b1;
        tick(1'b1, rand_op(), 1'b0, 24'h0);
        idle_ticks(5);
        do_reset();
        idle_ticks(3);
        stray = 1'b1;
        tick(1'b0, 24'h0, 1'b0, 24'h0);
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 24'h0, 1'b0, 24'h0);
            check_eq("post_reset_stray", all_outputs(), 64'h0);
        end

`ifdef RSA_ARB_TIMEOUT_EN
        do_reset();
        hang = 1'b1;
        tick(1'b1, rand_op(), 1'b0, 24'h0);
        drain(40);
        hang = 1'b0;
        check_eq("timeout_latency", 64'(last_done_cyc - last_start_cyc), 64'(TO + 1));
        check_eq("timeout_dout", 64'(r0_dout), 64'hFF);
        lat_force = 2;
        op_a = {8'd9, 8'd9, 8'd10};
        tick(1'b1, op_a, 1'b0, 24'h0);
        drain(20);
        check_eq("after_timeout_dout", 64'(r0_dout), 64'(modmul(op_a)));
`endif

        // Randomized traffic with random multiplier latency.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 3) == 0, rand_op(), $urandom_range(0, 3) == 0, rand_op());
        end
        drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
